// File: rtl/logic_issue_queue_pkg.sv
// rtl/logic_issue_queue_pkg.sv - shared op codes and widths for the logic issue queue
package logic_issue_queue_pkg;

  localparam int OP_W = 2;
  localparam int LU_W = 32;

  typedef enum logic [OP_W-1:0] {
    OP_NOR = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } logic_op_e;

endpackage

// File: rtl/logica_unit.sv
// rtl/logica_unit.sv - combinational 32-bit bitwise logic unit (NOR/AND/OR/XOR)
module logica_unit
  import logic_issue_queue_pkg::*;
(
  input  logic [LU_W-1:0] a,
  input  logic [LU_W-1:0] b,
  input  logic [OP_W-1:0] op,
  output logic [LU_W-1:0] out
);

  always_comb begin
    case (logic_op_e'(op))
      OP_NOR:  out = ~(a | b);
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      default: out = a ^ b;
    endcase
  end

endmodule

// File: rtl/logic_issue_queue.sv
// rtl/logic_issue_queue.sv - tagged request FIFO feeding a logic unit with a registered result slot
module logic_issue_queue
  import logic_issue_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         in_op,
  input  logic [DATA_W-1:0]       in_a,
  input  logic [DATA_W-1:0]       in_b,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [OP_W-1:0]         out_op,
  output logic [TAG_W-1:0]        out_tag,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            head;
  logic [LU_W-1:0]   head_res;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [OP_W-1:0]   out_op_q, out_op_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;

  logic push;
  logic advance;

  // A full FIFO refuses a push even when the head is leaving this cycle.
  assign in_ready = rst_n && (count_q < CNT_W'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;
  assign advance  = !flush && (count_q != '0) && (!out_valid_q || out_ready);
  assign head     = mem_q[rd_ptr_q];

  logica_unit u_logic_unit (
    .a   (head.a),
    .b   (head.b),
    .op  (head.op),
    .out (head_res)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_op_d    = out_op_q;
    out_tag_d   = out_tag_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (advance) begin
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        out_valid_d = 1'b1;
        out_data_d  = head_res;
        out_op_d    = head.op;
        out_tag_d   = head.tag;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      case ({push, advance})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_op_q    <= '0;
      out_tag_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_op_q    <= out_op_d;
      out_tag_q   <= out_tag_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{op: in_op, a: in_a, b: in_b, tag: in_tag};
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_op    = out_op_q;
  assign out_tag   = out_tag_q;
  assign count     = count_q;
  assign busy      = (count_q != '0) || out_valid_q;

endmodule

// File: tb/tb_logic_issue_queue.sv
// tb/tb_logic_issue_queue.sv - directed table and sequence checks for logic_issue_queue
module tb_logic_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_op;
  logic [3:0]  out_tag;
  logic [2:0]  count;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic_issue_queue #(.DATA_W(32), .DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_op(out_op), .out_tag(out_tag), .count(count), .busy(busy)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    logic [1:0]  op;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        iv;
    logic [1:0]  op;
    logic [3:0]  tag;
    logic        x_ir;
    logic        x_ov;
    logic [31:0] x_data;
    logic [3:0]  x_tag;
    logic [2:0]  x_cnt;
    logic        x_busy;
  } vec_t;

  function automatic logic [31:0] model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return ~(a | b);
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, score handshakes just before the edge, return #1 after it.
  task automatic step(input logic fl, input logic iv, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] tag, input logic ro, output logic ir_pre);
    logic pushed, popped;
    exp_t e;
    flush = fl; in_valid = iv; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = ro;
    #1;
    ir_pre = in_ready;
    pushed = in_valid && in_ready;
    popped = out_valid && out_ready && !fl;
    if (popped) begin
      chk("result_expected", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("res_data", out_data, e.data);
        chk("res_tag", out_tag, e.tag);
        chk("res_op", out_op, e.op);
      end
    end
    if (fl) sb.delete();
    else if (pushed) sb.push_back('{tag, model_op(op, a, b), op});
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[8];
  logic ir;
  logic [31:0] va, vb;
  logic [31:0] first_res;

  initial begin
    tbl[0] = '{1'b1, 2'b00, 4'd1, 1'b1, 1'b0, 32'h0000_0000, 4'd0, 3'd1, 1'b1};
    tbl[1] = '{1'b0, 2'b00, 4'd0, 1'b1, 1'b1, 32'hFFFF_FFF1, 4'd1, 3'd0, 1'b1};
    tbl[2] = '{1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 32'hFFFF_FFF1, 4'd1, 3'd0, 1'b0};
    tbl[3] = '{1'b1, 2'b01, 4'd2, 1'b1, 1'b0, 32'hFFFF_FFF1, 4'd1, 3'd1, 1'b1};
    tbl[4] = '{1'b1, 2'b10, 4'd3, 1'b1, 1'b1, 32'h0000_0008, 4'd2, 3'd1, 1'b1};
    tbl[5] = '{1'b1, 2'b11, 4'd4, 1'b1, 1'b1, 32'h0000_000E, 4'd3, 3'd1, 1'b1};
    tbl[6] = '{1'b0, 2'b00, 4'd0, 1'b1, 1'b1, 32'h0000_0006, 4'd4, 3'd0, 1'b1};
    tbl[7] = '{1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 32'h0000_0006, 4'd4, 3'd0, 1'b0};

    in_valid = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      step(1'b0, tbl[i].iv, tbl[i].op, 32'h0000_000A, 32'h0000_000C, tbl[i].tag, 1'b1, ir);
      chk($sformatf("vec%0d_in_ready", i), ir, tbl[i].x_ir);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].x_ov);
      chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].x_data);
      chk($sformatf("vec%0d_out_tag", i), out_tag, tbl[i].x_tag);
      chk($sformatf("vec%0d_count", i), count, tbl[i].x_cnt);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].x_busy);
    end

    // Backpressure: five accepted (four queued, one in the slot), sixth refused.
    for (int t = 5; t <= 9; t++) begin
      step(1'b0, 1'b1, 2'(t), 32'h1234_0000 + 32'(t), 32'hFFFF_00F0, 4'(t), 1'b0, ir);
      chk("bp_in_ready", ir, 1);
    end
    first_res = model_op(2'(5), 32'h1234_0005, 32'hFFFF_00F0);
    chk("bp_count_full", count, 4);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_data", out_data, first_res);
    chk("bp_out_tag", out_tag, 5);
    step(1'b0, 1'b1, 2'd2, 32'h1234_000A, 32'hFFFF_00F0, 4'd10, 1'b0, ir);
    chk("bp_full_refuse", ir, 0);
    chk("bp_count_hold", count, 4);
    chk("bp_data_stable", out_data, first_res);
    step(1'b0, 1'b1, 2'd2, 32'h1234_000A, 32'hFFFF_00F0, 4'd10, 1'b1, ir);
    chk("bp_no_passthrough", ir, 0);
    chk("bp_count_after_pop", count, 3);
    step(1'b0, 1'b1, 2'd2, 32'h1234_000A, 32'hFFFF_00F0, 4'd10, 1'b1, ir);
    chk("bp_sixth_accepted", ir, 1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0, 1'b1, ir);
    chk("bp_drained_count", count, 0);
    chk("bp_drained_valid", out_valid, 0);
    chk("bp_all_results", sb.size(), 0);

    // Streaming with pointer wrap.
    for (int i = 0; i < 10; i++) begin
      va = $urandom;
      vb = $urandom;
      step(1'b0, 1'b1, 2'(i), va, vb, 4'(i + 11), 1'b1, ir);
      chk("wrap_in_ready", ir, 1);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0, 1'b1, ir);
    chk("wrap_count", count, 0);
    chk("wrap_all_results", sb.size(), 0);
    chk("wrap_busy", busy, 0);

    // Flush with a request presented in the same cycle.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i), 32'hA5A5_0000 + 32'(i), 32'h0F0F_0F0F, 4'(i), 1'b0, ir);
    chk("fl_count_pre", count, 3);
    step(1'b1, 1'b1, 2'd3, 32'hDEAD_BEEF, 32'h1, 4'd15, 1'b0, ir);
    chk("fl_in_ready", ir, 0);
    chk("fl_count", count, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0, 1'b1, ir);
      chk("fl_no_stale", out_valid, 0);
    end

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h1357_9BDF, 4'(i + 7), 1'b0, ir);
    chk("mr_pre_valid", out_valid, 1);
    chk("mr_pre_count", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_out_data", out_data, 0);
    chk("mr_count", count, 0);
    chk("mr_in_ready", in_ready, 0);
    sb.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0, 1'b1, ir);
      chk("mr_no_result", out_valid, 0);
    end
    chk("mr_count_after", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
